// File: rtl/codec_audio_data_in_pio.sv
// codec_audio_data_in_pio
// Avalon-MM input port for the codec datapath status/data bus. in_port is
// brought into the clk domain through a two-flop synchronizer; a third flop
// keeps the previous synchronized value for per-bit edge detection. Detected
// edges latch into a sticky, write-1-to-clear edge_capture register, and any
// captured bit that is also set in irq_mask raises a level interrupt.
//
// Bus semantics: a read is any cycle with chipselect high and write_n high.
// readdata is combinational from registers (zero wait states, no side
// effects) and reads 0 whenever chipselect is low. A write is any cycle with
// chipselect high and write_n low; it takes effect at that rising clk edge.
// There is no backpressure: every access completes in the cycle presented.
module codec_audio_data_in_pio #(
  parameter int DATA_WIDTH = 20,
  parameter int EDGE_TYPE  = 0   // 0 = rising, 1 = falling, 2 = any
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);

  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_DIR   = 2'd1;
  localparam logic [1:0] ADDR_MASK  = 2'd2;
  localparam logic [1:0] ADDR_EDGE  = 2'd3;
  localparam logic [1:0] PRIME_DONE = 2'd3;

  logic [DATA_WIDTH-1:0] sync1_q;
  logic [DATA_WIDTH-1:0] sync2_q;
  logic [DATA_WIDTH-1:0] prev_q;
  logic [DATA_WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [DATA_WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [1:0]            prime_q, prime_d;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] edge_raw;
  logic [DATA_WIDTH-1:0] edge_det;
  logic [DATA_WIDTH-1:0] clr_bits;
  logic                  writedata_unused;

  assign wr_en = chipselect & ~write_n;
  assign wdata = writedata[DATA_WIDTH-1:0];
  // Upper writedata bits are deliberately ignored.
  assign writedata_unused = ^writedata;

  // Synchronizer chain plus the previous-value flop used for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Prime counter: counts up to 3 after reset and then holds.
  always_comb begin
    prime_d = prime_q;
    if (prime_q != PRIME_DONE) prime_d = prime_q + 2'd1;
  end

  // Per-bit edge detection, gated until the synchronizer holds real data so
  // that reset-value flops never look like an edge.
  always_comb begin
    edge_raw = '0;
    case (EDGE_TYPE)
      1:       edge_raw = ~sync2_q & prev_q;
      2:       edge_raw = sync2_q ^ prev_q;
      default: edge_raw = sync2_q & ~prev_q;
    endcase
    edge_det = (prime_q == PRIME_DONE) ? edge_raw : '0;
  end

  // Register writes: mask load and sticky capture with set-over-clear.
  always_comb begin
    irq_mask_d = irq_mask_q;
    clr_bits   = '0;
    if (wr_en && address == ADDR_MASK) irq_mask_d = wdata;
    if (wr_en && address == ADDR_EDGE) clr_bits = wdata;
    edge_cap_d = edge_det | (edge_cap_q & ~clr_bits);
  end

  // State registers for mask, captures and prime counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      prime_q    <= 2'd0;
    end else begin
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      prime_q    <= prime_d;
    end
  end

  // Zero-wait-state read mux, zero-extended and gated by chipselect.
  always_comb begin
    readdata = '0;
    if (chipselect) begin
      case (address)
        ADDR_DATA: readdata[DATA_WIDTH-1:0] = sync2_q;
        ADDR_DIR:  readdata = '0;
        ADDR_MASK: readdata[DATA_WIDTH-1:0] = irq_mask_q;
        ADDR_EDGE: readdata[DATA_WIDTH-1:0] = edge_cap_q;
        default:   readdata = '0;
      endcase
    end
  end

  assign irq = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_codec_audio_data_in_pio.sv
// Directed testbench for codec_audio_data_in_pio. Three instances share the
// bus and reset (rising, falling and any-edge); each has its own in_port.
// Driver tasks push expected values into queues; a monitor on the falling
// edge pops and compares whenever a read (or an irq check) is presented.
module tb_codec_audio_data_in_pio;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [19:0] in0, in1, in2;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  codec_audio_data_in_pio #(.DATA_WIDTH(20), .EDGE_TYPE(0)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in0),
    .readdata(rd0), .irq(irq0));

  codec_audio_data_in_pio #(.DATA_WIDTH(20), .EDGE_TYPE(1)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in1),
    .readdata(rd1), .irq(irq1));

  codec_audio_data_in_pio #(.DATA_WIDTH(20), .EDGE_TYPE(2)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in2),
    .readdata(rd2), .irq(irq2));

  // Instance under observation for the monitor.
  int          sel;
  logic [31:0] rd_cur;
  logic        irq_cur;
  always_comb begin
    rd_cur  = rd0;
    irq_cur = irq0;
    case (sel)
      1: begin rd_cur = rd1; irq_cur = irq1; end
      2: begin rd_cur = rd2; irq_cur = irq2; end
      default: ;
    endcase
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        irq_q[$];
  string       irq_name_q[$];
  logic        irq_chk;
  logic        done;
  int          checks;
  int          errors;

  always @(negedge clk) begin
    logic [31:0] e;
    logic        ei;
    string       n;
    if (chipselect && write_n) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read got=%h required=<none>", rd_cur);
      end else begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (rd_cur !== e) begin
          errors++;
          $display("FAIL %s inst=%0d got=%h required=%h", n, sel, rd_cur, e);
        end
      end
    end
    if (irq_chk) begin
      checks++;
      if (irq_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_irq_check got=%b required=<none>", irq_cur);
      end else begin
        ei = irq_q.pop_front();
        n  = irq_name_q.pop_front();
        if (irq_cur !== ei) begin
          errors++;
          $display("FAIL %s inst=%0d got=%b required=%b", n, sel, irq_cur, ei);
        end
      end
    end
    if (done) begin
      checks++;
      if (exp_q.size() != 0 || irq_q.size() != 0) begin
        errors++;
        $display("FAIL queues_drained got=%0d/%0d required=0/0",
                 exp_q.size(), irq_q.size());
      end
    end
  end

  // ---------------- driver tasks (all start and end at posedge+1) -------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string n);
    address    = a;
    write_n    = 1'b1;
    chipselect = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
    #1;
    chipselect = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    write_n    = 1'b0;
    chipselect = 1'b1;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic chk_irq(input logic e, input string n);
    irq_q.push_back(e);
    irq_name_q.push_back(n);
    irq_chk = 1'b1;
    @(posedge clk);
    #1;
    irq_chk = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks     = 0;
    errors     = 0;
    done       = 1'b0;
    irq_chk    = 1'b0;
    sel        = 0;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in0        = 20'hFFFFF;
    in1        = 20'h0;
    in2        = 20'h0;

    // Reset state, in_port held all-ones through reset release.
    cyc(2);
    rd(2'd3, 32'h0, "cap_in_reset");
    rd(2'd0, 32'h0, "data_in_reset");
    chk_irq(1'b0, "irq_in_reset");
    reset_n = 1'b1;
    cyc(2);
    for (int i = 0; i < 10; i++) begin
      rd(2'd3, 32'h0, "cap_after_reset_release");
      chk_irq(1'b0, "irq_after_reset_release");
      rd(2'd0, 32'h000FFFFF, "data_all_ones");
    end
    rd(2'd1, 32'h0, "dir_reads_zero");

    // Falling transitions are ignored by the rising instance.
    in0 = 20'h0;
    cyc(4);
    rd(2'd3, 32'h0, "cap_no_rise_on_fall");
    rd(2'd0, 32'h0, "data_zero");

    // Two-cycle pulse on bit 0 with bit 0 masked in.
    wr(2'd2, 32'h1);
    rd(2'd2, 32'h1, "mask_readback");
    in0[0] = 1'b1;
    cyc(2);
    in0[0] = 1'b0;
    cyc(2);
    rd(2'd3, 32'h1, "cap_bit0_pulse");
    chk_irq(1'b1, "irq_after_pulse");
    chk_irq(1'b1, "irq_stays_high");
    wr(2'd3, 32'h1);
    chk_irq(1'b0, "irq_drop_after_w1c");
    rd(2'd3, 32'h0, "cap_cleared_bit0");

    // Bit 5 edge detected in the same cycle as its write-1-to-clear.
    in0[5] = 1'b1;
    cyc(2);
    wr(2'd3, 32'h20);
    rd(2'd3, 32'h20, "cap_set_wins_over_clear");
    chk_irq(1'b0, "irq_bit5_unmasked");
    in0[5] = 1'b0;
    cyc(3);
    wr(2'd3, 32'h20);
    rd(2'd3, 32'h0, "cap_w1c_bit5");

    // Mask 0, bits 3 and 7 toggled, then mask bit 7 in.
    wr(2'd2, 32'h0);
    in0 = 20'h00088;
    cyc(3);
    in0 = 20'h0;
    cyc(3);
    rd(2'd3, 32'h88, "cap_bits_3_7");
    chk_irq(1'b0, "irq_mask_zero");
    wr(2'd2, 32'h80);
    chk_irq(1'b1, "irq_after_mask_write");
    rd(2'd2, 32'h80, "mask_0x80");
    wr(2'd2, 32'hFFF00000);
    rd(2'd2, 32'h0, "mask_upper_bits_ignored");
    chk_irq(1'b0, "irq_after_mask_clear");
    wr(2'd3, 32'h88);
    rd(2'd3, 32'h0, "cap_cleared_3_7");

    // Bit 10 toggled 0 -> 1 -> 0 -> 1 on the falling and any instances.
    in1[10] = 1'b1;
    in2[10] = 1'b1;
    cyc(4);
    sel = 1; rd(2'd3, 32'h0,   "fall_no_cap_on_rise");
    sel = 2; rd(2'd3, 32'h400, "any_cap_on_rise");
    sel = 2; rd(2'd0, 32'h400, "any_data_bit10");
    wr(2'd3, 32'h400);
    sel = 2; rd(2'd3, 32'h0,   "any_cleared");
    in1[10] = 1'b0;
    in2[10] = 1'b0;
    cyc(4);
    sel = 1; rd(2'd3, 32'h400, "fall_cap_on_fall");
    sel = 2; rd(2'd3, 32'h400, "any_cap_on_fall");
    wr(2'd3, 32'h400);
    in1[10] = 1'b1;
    in2[10] = 1'b1;
    cyc(4);
    sel = 1; rd(2'd3, 32'h0,   "fall_no_cap_on_second_rise");
    sel = 2; rd(2'd3, 32'h400, "any_recap_after_clear");
    sel = 0; rd(2'd3, 32'h0,   "rise_unaffected_bit10");

    // Asynchronous reset mid-cycle with a capture pending and mask non-zero.
    wr(2'd2, 32'hFF);
    in0[3] = 1'b1;
    cyc(4);
    rd(2'd3, 32'h8, "cap_bit3_before_reset");
    chk_irq(1'b1, "irq_before_reset");
    address    = 2'd3;
    write_n    = 1'b1;
    chipselect = 1'b1;
    exp_q.push_back(32'h0);
    name_q.push_back("cap_async_reset");
    irq_q.push_back(1'b0);
    irq_name_q.push_back("irq_async_reset");
    irq_chk = 1'b1;
    #2 reset_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    irq_chk    = 1'b0;
    rd(2'd2, 32'h0, "mask_in_reset");
    rd(2'd0, 32'h0, "data_in_mid_reset");
    rd(2'd1, 32'h0, "dir_in_reset");
    reset_n = 1'b1;
    wr(2'd0, 32'hFFFFFFFF);
    wr(2'd1, 32'hFFFFFFFF);
    rd(2'd1, 32'h0, "dir_after_write");
    rd(2'd2, 32'h0, "mask_after_reset");
    rd(2'd3, 32'h0, "cap_after_reset");
    cyc(3);
    rd(2'd0, 32'h8, "data_not_written");
    rd(2'd3, 32'h0, "cap_primed_no_spurious");
    chk_irq(1'b0, "irq_after_reset");

    cyc(2);
    done = 1'b1;
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
